// File: rtl/mem_access_pkg.sv
// mem_access_pkg: memory op and FSM state encodings shared by the memory-access stage
package mem_access_pkg;
    localparam int MEM_OP_BUS = 4;
    typedef enum logic [MEM_OP_BUS-1:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LBU = 4'd2,
        MEM_LH  = 4'd3,
        MEM_LHU = 4'd4,
        MEM_LW  = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_op_e;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/mem_access_lane_align.sv
// mem_lane_align: little-endian byte-lane steering for stores and load extraction/extension
//   i_op/i_addr/i_st_data -> o_wstrb, o_wdata, o_misaligned (store direction, alignment check)
//   i_ld_word/i_addr/i_op -> o_ld_data (load direction)
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [MEM_OP_BUS-1:0] i_op,
    input  logic [1:0]            i_addr,
    input  logic [31:0]           i_st_data,
    input  logic [31:0]           i_ld_word,
    output logic [3:0]            o_wstrb,
    output logic [31:0]           o_wdata,
    output logic [31:0]           o_ld_data,
    output logic                  o_misaligned
);
    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shift = i_ld_word >> {i_addr, 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = i_addr[1] ? i_ld_word[31:16] : i_ld_word[15:0];

    always_comb begin
        o_ld_data    = i_op == MEM_LB  ? {{24{w_byte[7]}}, w_byte} :
                       i_op == MEM_LBU ? {24'd0, w_byte} :
                       i_op == MEM_LH  ? {{16{w_half[15]}}, w_half} :
                       i_op == MEM_LHU ? {16'd0, w_half} : i_ld_word;
        o_wstrb      = i_op == MEM_SB ? 4'b0001 << i_addr :
                       i_op == MEM_SH ? (i_addr[1] ? 4'b1100 : 4'b0011) :
                       i_op == MEM_SW ? 4'b1111 : 4'b0000;
        o_wdata      = i_op == MEM_SB ? {4{i_st_data[7:0]}} :
                       i_op == MEM_SH ? {2{i_st_data[15:0]}} :
                       i_op == MEM_SW ? i_st_data : 32'd0;
        o_misaligned = ((i_op == MEM_LH || i_op == MEM_LHU || i_op == MEM_SH) && i_addr[0]) ||
                       ((i_op == MEM_LW || i_op == MEM_SW) && i_addr != 2'b00);
    end
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage issuing one req/ack data-bus access per load/store
//   inputs : EX/MEM results (mem op/addr/store data, reg and HI/LO write fields), bus ack/rdata
//   outputs: registered bus request fields, stall, misalignment flag, MEM/WB forwarding view
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MEM_OP_BUS-1:0] mem_op_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     mem_store_data_i,
    input  logic [31:0]           reg_write_data_i,
    input  logic [4:0]            reg_write_addr_i,
    input  logic                  reg_write_en_i,
    input  logic [31:0]           hi_write_data_i,
    input  logic [31:0]           lo_write_data_i,
    input  logic                  hilo_write_en_i,
    output logic                  data_req_o,
    output logic                  data_wr_o,
    output logic [ADDR_W-1:0]     data_addr_o,
    output logic [3:0]            data_wstrb_o,
    output logic [31:0]           data_wdata_o,
    input  logic                  data_ack_i,
    input  logic [31:0]           data_rdata_i,
    output logic                  stall_req_o,
    output logic                  addr_err_o,
    output logic [31:0]           reg_write_data_o,
    output logic [4:0]            reg_write_addr_o,
    output logic                  reg_write_en_o,
    output logic [31:0]           hi_write_data_o,
    output logic [31:0]           lo_write_data_o,
    output logic                  hilo_write_en_o
);
    state_e            r_state;
    logic              r_req;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_wstrb;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              w_is_load;
    logic              w_is_store;
    logic              w_is_mem;
    logic              w_misaligned;
    logic              w_go;
    logic [3:0]        w_wstrb;
    logic [31:0]       w_wdata;
    logic [31:0]       w_ld_data;

    mem_lane_align u_align (
        .i_op         (mem_op_i),
        .i_addr       (mem_addr_i[1:0]),
        .i_st_data    (mem_store_data_i),
        .i_ld_word    (r_rdata),
        .o_wstrb      (w_wstrb),
        .o_wdata      (w_wdata),
        .o_ld_data    (w_ld_data),
        .o_misaligned (w_misaligned)
    );

    // Op codes outside 1..8 fall through as NOP.
    assign w_is_load  = mem_op_i >= MEM_LB && mem_op_i <= MEM_LW;
    assign w_is_store = mem_op_i >= MEM_SB && mem_op_i <= MEM_SW;
    assign w_is_mem   = w_is_load || w_is_store;
    assign w_go       = r_state == IDLE && w_is_mem && !w_misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wstrb <= 4'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            case (r_state)
                IDLE: if (w_go) begin
                    r_req   <= 1'b1;
                    r_wr    <= w_is_store;
                    r_addr  <= mem_addr_i;
                    r_wstrb <= w_wstrb;
                    r_wdata <= w_wdata;
                    r_state <= BUSY;
                end
                BUSY: if (data_ack_i) begin
                    r_rdata <= data_rdata_i;
                    r_req   <= 1'b0;
                    r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_req_o   = r_req;
    assign data_wr_o    = r_wr;
    assign data_addr_o  = r_addr;
    assign data_wstrb_o = r_wstrb;
    assign data_wdata_o = r_wdata;

    // Load/store ops only expose a register write once the captured data is final (DONE, loads).
    always_comb begin
        stall_req_o      = !rst && (w_go || r_state == BUSY);
        addr_err_o       = !rst && r_state == IDLE && w_is_mem && w_misaligned;
        reg_write_data_o = rst ? 32'd0 : (r_state == DONE && w_is_load) ? w_ld_data : reg_write_data_i;
        reg_write_en_o   = !rst && (w_is_mem ? (r_state == DONE && w_is_load && reg_write_en_i) : reg_write_en_i);
        reg_write_addr_o = rst ? 5'd0 : reg_write_addr_i;
        hi_write_data_o  = rst ? 32'd0 : hi_write_data_i;
        lo_write_data_o  = rst ? 32'd0 : lo_write_data_i;
        hilo_write_en_o  = !rst && hilo_write_en_i;
    end
endmodule
